// File: rtl/exc_track.sv
// exc_track: fetch-stage exception detection plus branch-delay tracking for the
// pipelined MIPS CPU. {valid, pc, ExcCode, BD} travels through DEPTH stage
// registers; exceptions found later in the pipe are merged in, and the commit
// stage (DEPTH) raises one exception/interrupt request with EPC and BD to CP0.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   pc_f, br_f, ri_f    fetch-stage PC, branch/jump flag, reserved-instruction flag
//   exc_in, exc_in_vld  late ExcCode per stage (slot k-1 = stage k) and qualifiers
//   stall, flush        hold stages 1..STALL_STAGE / clear the whole pipe (eret)
//   int_req             masked interrupt pending from CP0
//   exc_code_f          F-stage ExcCode (combinational)
//   stage_exc           per-stage "valid instruction with nonzero effective code"
//   exc_req, exc_code, exc_bd, epc   commit-stage request to CP0 (combinational)
module exc_track #(
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned STALL_STAGE = 1,
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4ffc
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          pc_f,
    input  logic                 br_f,
    input  logic                 ri_f,
    input  logic [5*DEPTH-1:0]   exc_in,
    input  logic [DEPTH-1:0]     exc_in_vld,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 int_req,
    output logic [4:0]           exc_code_f,
    output logic [DEPTH-1:0]     stage_exc,
    output logic                 exc_req,
    output logic [4:0]           exc_code,
    output logic                 exc_bd,
    output logic [31:0]          epc
);

    localparam int unsigned LAST = DEPTH - 1;
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_RI   = 5'd10;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  code;
        logic        bd;
    } stage_t;

    stage_t     stage_q [DEPTH];
    stage_t     stage_d [DEPTH];
    stage_t     up      [DEPTH];   // what each stage loads when it advances
    logic [4:0] eff     [DEPTH];
    stage_t     stage_f;
    logic       prev_br_q;
    logic       prev_br_d;
    logic       adel_f;
    logic       flush_c;

    // Fetch-stage detection; AdEL masks RI and the branch flag
    always_comb begin
        adel_f     = (pc_f[1:0] != 2'b00) || (pc_f < PC_LO) || (pc_f > PC_HI);
        exc_code_f = adel_f ? EXC_ADEL : (ri_f ? EXC_RI : 5'd0);
        stage_f    = '{valid: 1'b1, pc: pc_f, code: exc_code_f, bd: prev_br_q};
    end

    // Effective code: earliest-detected exception wins; injections into bubbles ignored
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            eff[i] = stage_q[i].code;
            if ((stage_q[i].code == 5'd0) && stage_q[i].valid && exc_in_vld[i]) begin
                eff[i] = exc_in[5*i +: 5];
            end
            stage_exc[i] = stage_q[i].valid && (eff[i] != 5'd0);
        end
    end

    // Commit-stage request; interrupt takes priority over any exception
    always_comb begin
        exc_req  = stage_q[LAST].valid && (int_req || (eff[LAST] != 5'd0));
        exc_code = int_req ? EXC_INT : eff[LAST];
        exc_bd   = stage_q[LAST].bd;
        epc      = stage_q[LAST].bd ? (stage_q[LAST].pc - 32'd4) : stage_q[LAST].pc;
        flush_c  = flush || exc_req;
    end

    // Upstream view of every stage, with the merged code carried forward
    always_comb begin
        up[0] = stage_f;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            up[i]      = stage_q[i-1];
            up[i].code = eff[i-1];
        end
    end

    // Next state: flush beats stall; a stall holds 1..STALL_STAGE and bubbles the next stage
    always_comb begin
        prev_br_d = prev_br_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        if (flush_c) begin
            prev_br_d = 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
        end else if (stall) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (i == STALL_STAGE) begin
                    stage_d[i] = '0;
                end else if (i > STALL_STAGE) begin
                    stage_d[i] = up[i];
                end
            end
        end else begin
            prev_br_d = br_f && !adel_f;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_d[i] = up[i];
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_br_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            prev_br_q <= prev_br_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

endmodule

// File: doc/exc_track.md
# exc_track

Parametrised exception tracker for the pipelined MIPS CPU. It detects fetch-stage exceptions (AdEL, RI) and tracks the branch-delay (BD) status of each instruction. It carries `{valid, pc, ExcCode, BD}` through `DEPTH` pipeline registers and merges exceptions detected later in the pipe. At the commit stage it issues one exception or interrupt request, with EPC and BD, to CP0.

## Interface
- `DEPTH`, 3: number of stage registers after F; stage 1 = D, stage `DEPTH` = commit (M). Minimum 2.
- `STALL_STAGE`, 1: the highest stage held by `stall`. Legal range 1..`DEPTH`-1.
- `PC_LO`, 32'h0000_3000: lowest legal fetch address.
- `PC_HI`, 32'h0000_4ffc: highest legal fetch address.

Ports (clock and reset first):
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_f` in 32: PC of the instruction in F.
- `br_f` in 1: the instruction in F is a branch or jump (beq, j, jal, jr).
- `ri_f` in 1: the decoder does not recognise the instruction in F.
- `exc_in` in 5*`DEPTH`: late ExcCode per stage; slot k-1 (`[5k-1:5k-5]`) belongs to stage k.
- `exc_in_vld` in `DEPTH`: bit k-1 qualifies slot k-1.
- `stall` in 1: pipeline stall request.
- `flush` in 1: external flush (eret).
- `int_req` in 1: masked interrupt pending from CP0.
- `exc_code_f` out 5: F-stage ExcCode, combinational.
- `stage_exc` out `DEPTH`: bit k-1 = stage k holds a valid instruction with a nonzero effective code; downstream logic uses it to suppress side effects.
- `exc_req` out 1: take the exception or interrupt this cycle.
- `exc_code` out 5: ExcCode sent to CP0 Cause[6:2].
- `exc_bd` out 1: BD bit of the committing instruction.
- `epc` out 32: EPC value.

## Operation
- ExcCodes: Int = 0, AdEL = 4, AdES = 5, RI = 10, Ov = 12. A code of 0 in a stage register means no exception.
- F detection:
  - AdEL when `pc_f[1:0]!=0`, `pc_f<PC_LO` or `pc_f>PC_HI`.
  - Otherwise RI when `ri_f`.
  - Otherwise 0.
  - AdEL masks both RI and `br_f`.
- BD tracking:
  - `prev_br` register loads `br_f & ~AdEL` whenever F advances (no stall, no flush).
  - BD of the F instruction is `prev_br`.
- Effective code of stage k:
  - `eff_k` = the register code when it is nonzero (the earliest-detected exception wins).
  - Otherwise `exc_in` slot k-1 when `valid_k & exc_in_vld[k-1]`.
  - Otherwise 0.
  - Injections into bubbles are ignored.
- Stage advance each cycle, in priority order:
  - If `reset`, or a flush cycle (`flush | exc_req`): every stage register is cleared (valid 0, pc 0, code 0, bd 0) and `prev_br` is cleared.
  - Else if `stall`: stages 1..`STALL_STAGE` hold, stage `STALL_STAGE`+1 loads a bubble, and later stages advance.
  - Else: stage k loads `{valid_{k-1}, pc_{k-1}, eff_{k-1}, bd_{k-1}}`. Stage 0 is F, which is always valid and uses `exc_code_f`.
- Commit, at stage `DEPTH`:
  - `exc_req = valid_DEPTH & (int_req | eff_DEPTH!=0)`.
  - `exc_code` = 0 if `int_req`, else `eff_DEPTH`. The interrupt has priority over exceptions.
  - `exc_bd = bd_DEPTH`.
  - `epc = bd_DEPTH ? pc_DEPTH-4 : pc_DEPTH`, 32-bit with wrap.
- Interrupt with a bubble at commit: no request. The interrupt waits until a valid instruction reaches stage `DEPTH`.

## Timing
- Reset values:
  - All stage registers and `prev_br` = 0.
  - `exc_req`=0, `exc_code`=0, `exc_bd`=0, `epc`=0, `stage_exc`=0.
  - `exc_code_f` follows `pc_f`/`ri_f` combinationally.
- Latency: an instruction in F at cycle t reaches commit at t+`DEPTH` when no stall occurs.
- Outputs:
  - `exc_req`, `exc_code`, `exc_bd`, `epc` and `stage_exc` are combinational from the stage registers and the current-cycle injections.
  - `exc_req` is high for exactly one cycle per event, because the flush takes effect at the following edge.
- Simultaneous events:
  - Flush beats stall.
  - `exc_req` together with `stall` still clears every stage.
  - Reset mid-pipeline discards all in-flight state with no request.

## Test plan
- Reset, then `pc_f`=0x3000, 0x3004, 0x3008 with `ri_f`=0 -> `exc_code_f`=0; `exc_req` stays 0 throughout.
- `pc_f`=0x3002 (and separately 0x5000), `DEPTH`=3 -> `exc_code_f`=4 immediately. Three cycles later: `exc_req`=1, `exc_code`=4, `epc` = that PC, `exc_bd`=0. On the next cycle `stage_exc`=0.
- Branch at 0x3000 (`br_f`=1), then 0x3004 with `ri_f`=1 -> at commit of 0x3004: `exc_code`=10, `exc_bd`=1, `epc`=0x3000.
- Instruction with `ri_f`=1, and Ov=12 injected on `exc_in` slot 1 while it is in stage 2 -> committed `exc_code`=10.
- `stall` for 2 cycles while an instruction sits in D, `int_req`=1 throughout:
  - D holds; bubbles enter E and M.
  - No `exc_req` while M holds a bubble.
  - `exc_req`=1, `exc_code`=0 when the first valid instruction reaches M.
- `exc_req` and `stall` in the same cycle, with `prev_br`=1 -> next cycle all valid bits are 0 and `prev_br`=0. The first F instruction after the flush commits with `exc_bd`=0.
